// File: rtl/instr_mem_fetch_unit.sv
// Multi-cycle instruction memory with a READ/BUSYWAIT handshake and a byte-wide program port.
// Optional next-word prefetch buffer is enabled by defining INSTR_MEM_PREFETCH_EN.
module instr_mem_fetch_unit #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_read,
    input  logic [ADDR_W-1:0]         i_address,
    output logic [8*WORD_BYTES-1:0]   o_readdata,
    output logic                      o_busywait,
    input  logic                      i_prog_we,
    input  logic [ADDR_W-1:0]         i_prog_addr,
    input  logic [7:0]                i_prog_data
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam int unsigned       INSTR_W  = 8 * WORD_BYTES;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORD_BYTES - 1);
    localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [7:0]         r_mem [DEPTH];
    logic [1:0]         r_state;
    logic [1:0]         w_state_d;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_d;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_d;
    logic [INSTR_W-1:0] r_readdata;
    logic [INSTR_W-1:0] w_readdata_d;
    logic [INSTR_W-1:0] w_mem_word;
    logic [ADDR_W-1:0]  w_req_addr;

`ifdef INSTR_MEM_PREFETCH_EN
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

    logic               r_pf_valid;
    logic               w_pf_valid_d;
    logic               r_pf_busy;
    logic               w_pf_busy_d;
    logic [ADDR_W-1:0]  r_pf_addr;
    logic [ADDR_W-1:0]  w_pf_addr_d;
    logic [3:0]         r_pf_cnt;
    logic [3:0]         w_pf_cnt_d;
    logic [INSTR_W-1:0] r_pf_data;
    logic [INSTR_W-1:0] w_pf_data_d;
    logic [INSTR_W-1:0] w_pf_word;
    logic               w_hit;
    logic               w_join;
    logic               w_enter_done;
`endif

    assign w_req_addr = i_address & ~OFF_MASK;
    assign o_readdata = r_readdata;

    // Memory has no reset: program writes land even while control state is held in reset.
    always_ff @(posedge i_clk) begin
        if (i_prog_we) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_comb begin
        w_mem_word = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            w_mem_word[8*i +: 8] = r_mem[r_addr + ADDR_W'(i)];
        end
    end

`ifdef INSTR_MEM_PREFETCH_EN
    always_comb begin
        w_pf_word = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            w_pf_word[8*i +: 8] = r_mem[r_pf_addr + ADDR_W'(i)];
        end
    end

    assign w_hit  = (r_state == ST_IDLE) && i_read && r_pf_valid && (w_req_addr == r_pf_addr);
    assign w_join = (r_state == ST_IDLE) && i_read && r_pf_busy && (w_req_addr == r_pf_addr);
    assign o_busywait = i_read && (r_state != ST_DONE) && !w_hit;
`else
    assign o_busywait = i_read && (r_state != ST_DONE);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_addr_d     = r_addr;
        w_readdata_d = r_readdata;
`ifdef INSTR_MEM_PREFETCH_EN
        w_enter_done = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef INSTR_MEM_PREFETCH_EN
                if (w_hit) begin
                    w_state_d    = ST_DONE;
                    w_addr_d     = w_req_addr;
                    w_readdata_d = r_pf_data;
                    w_enter_done = 1'b1;
                end else
`endif
                if (i_read) begin
                    w_state_d = ST_WAIT;
                    w_addr_d  = w_req_addr;
                    w_cnt_d   = CNT_INIT;
`ifdef INSTR_MEM_PREFETCH_EN
                    // Joining an in-flight prefetch of this word keeps its remaining count.
                    if (w_join) begin
                        w_cnt_d = (r_pf_cnt != 4'd0) ? r_pf_cnt - 4'd1 : 4'd0;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (!i_read) begin
                    w_state_d = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_d    = ST_DONE;
                    w_readdata_d = w_mem_word;
`ifdef INSTR_MEM_PREFETCH_EN
                    w_enter_done = 1'b1;
`endif
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_readdata <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_addr     <= w_addr_d;
            r_readdata <= w_readdata_d;
        end
    end

`ifdef INSTR_MEM_PREFETCH_EN
    always_comb begin
        w_pf_valid_d = r_pf_valid;
        w_pf_busy_d  = r_pf_busy;
        w_pf_addr_d  = r_pf_addr;
        w_pf_cnt_d   = r_pf_cnt;
        w_pf_data_d  = r_pf_data;
        if (r_pf_busy) begin
            if (r_pf_cnt == 4'd0) begin
                w_pf_data_d  = w_pf_word;
                w_pf_valid_d = 1'b1;
                w_pf_busy_d  = 1'b0;
            end else begin
                w_pf_cnt_d = r_pf_cnt - 4'd1;
            end
        end
        // A demand request that is not a hit owns the memory from here on.
        if ((r_state == ST_IDLE) && i_read && !w_hit) begin
            w_pf_busy_d = 1'b0;
        end
        if (i_prog_we && ((i_prog_addr & ~OFF_MASK) == r_pf_addr)) begin
            w_pf_valid_d = 1'b0;
            w_pf_busy_d  = 1'b0;
        end
        if (w_enter_done) begin
            w_pf_addr_d  = w_addr_d + WORD_STEP;
            w_pf_cnt_d   = CNT_INIT;
            w_pf_busy_d  = 1'b1;
            w_pf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pf_valid <= 1'b0;
            r_pf_busy  <= 1'b0;
            r_pf_addr  <= '0;
            r_pf_cnt   <= 4'd0;
            r_pf_data  <= '0;
        end else begin
            r_pf_valid <= w_pf_valid_d;
            r_pf_busy  <= w_pf_busy_d;
            r_pf_addr  <= w_pf_addr_d;
            r_pf_cnt   <= w_pf_cnt_d;
            r_pf_data  <= w_pf_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_fetch_unit.sv
// Directed bench for instr_mem_fetch_unit: a 10-bit-address instance plus a 3-bit-address
// instance for the wrap path, with a byte-array model and an expected-word queue.
module tb_instr_mem_fetch_unit;

    localparam int LAT  = 4;
    localparam int MISS = LAT + 1;
`ifdef INSTR_MEM_PREFETCH_EN
    localparam int SEQ  = 0;
    localparam int JOIN = 3;
`else
    localparam int SEQ  = MISS;
    localparam int JOIN = MISS;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic [9:0]  address;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [31:0] readdata_m;
    logic [31:0] readdata_w;
    logic        busywait_m;
    logic        busywait_w;
    logic        sel;
    logic        bw;
    logic [31:0] rd;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    logic [7:0]  model   [1024];
    logic [7:0]  model_w [8];

    always #5 clk = ~clk;

    assign bw = sel ? busywait_w : busywait_m;
    assign rd = sel ? readdata_w : readdata_m;

    instr_mem_fetch_unit #(.ADDR_W(10), .WORD_BYTES(4), .LATENCY(LAT)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_read      (read),
        .i_address   (address),
        .o_readdata  (readdata_m),
        .o_busywait  (busywait_m),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data)
    );

    instr_mem_fetch_unit #(.ADDR_W(3), .WORD_BYTES(4), .LATENCY(LAT)) u_dut_wrap (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_read      (read),
        .i_address   (address[2:0]),
        .o_readdata  (readdata_w),
        .o_busywait  (busywait_w),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr[2:0]),
        .i_prog_data (prog_data)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [9:0] a, input logic s);
        logic [31:0] w;
        logic [9:0]  al;
        logic [2:0]  aw;
        al = a & 10'h3FC;
        aw = a[2:0] & 3'b100;
        w  = '0;
        for (int i = 0; i < 4; i++) begin
            if (s) w[8*i +: 8] = model_w[aw + 3'(i)];
            else   w[8*i +: 8] = model[al + 10'(i)];
        end
        return w;
    endfunction

    task automatic prog_byte(input logic [9:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        @(negedge clk);
        prog_we       = 1'b0;
        model[a]      = d;
        model_w[a[2:0]] = d;
    endtask

    // Starts at a negedge with the DUT idle; optionally moves ADDRESS or writes a byte
    // just before edge number chg_at / we_at of the request.
    task automatic fetch(input logic [9:0] a, input int exp_edges, input string tag,
                         input int chg_at = -1, input logic [9:0] chg_addr = '0,
                         input int we_at = -1, input logic [9:0] we_a = '0,
                         input logic [7:0] we_d = '0);
        int          edges;
        logic [31:0] exp_word;
        exp_q.push_back(model_word(a, sel));
        read    = 1'b1;
        address = a;
        #1;
        edges = 0;
        while (bw && edges < 40) begin
            if (edges == chg_at) address = chg_addr;
            if (edges == we_at) begin
                prog_we   = 1'b1;
                prog_addr = we_a;
                prog_data = we_d;
            end
            @(posedge clk);
            @(negedge clk);
            if (prog_we) begin
                prog_we            = 1'b0;
                model[we_a]        = we_d;
                model_w[we_a[2:0]] = we_d;
            end
            edges++;
        end
        if (edges == 0) begin
            @(posedge clk);
            @(negedge clk);
        end
        check32({tag, "_lat"}, 32'(edges), 32'(exp_edges));
        exp_word = exp_q.pop_front();
        check32({tag, "_data"}, rd, exp_word);
        last_exp = exp_word;
        read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        read      = 1'b0;
        address   = '0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        sel       = 1'b0;
        last_exp  = '0;
        repeat (2) @(negedge clk);

        check32("rst_data", rd, 32'h0);
        check32("rst_busy_idle", 32'(bw), 32'h0);
        read = 1'b1;
        #1;
        check32("rst_busy_read", 32'(bw), 32'h1);
        check32("rst_busy_read_w", 32'(busywait_w), 32'h1);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 'h50; i++) prog_byte(10'(i), 8'($urandom));
        for (int i = 'h3FC; i < 'h400; i++) prog_byte(10'(i), 8'($urandom));
        prog_byte(10'h000, 8'h00);
        prog_byte(10'h001, 8'h00);
        prog_byte(10'h002, 8'h00);
        prog_byte(10'h003, 8'h02);

        fetch(10'h000, MISS, "miss0");
        check32("miss0_const", rd, 32'h0200_0000);

        // Reset in the middle of WAIT: no load may follow and memory must survive.
        read    = 1'b1;
        address = 10'h000;
        repeat (2) @(negedge clk);
        check32("rstwait_busy", 32'(bw), 32'h1);
        rst_n = 1'b0;
        #1;
        check32("rstwait_data", rd, 32'h0);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (MISS + 2) @(negedge clk);
        check32("rstwait_nodone", rd, 32'h0);
        fetch(10'h000, MISS, "after_rst");
        check32("after_rst_const", rd, 32'h0200_0000);

        fetch(10'h3FF, MISS, "top_word");
        fetch(10'h010, MISS, "pat10");
        fetch(10'h01E, MISS, "pat1e");
        fetch(10'h015, MISS, "pat15");

        fetch(10'h000, MISS, "addr_chg", 2, 10'h008);

        read    = 1'b1;
        address = 10'h020;
        repeat (2) @(negedge clk);
        read = 1'b0;
        repeat (MISS + 2) @(negedge clk);
        check32("abort_hold", rd, last_exp);
        fetch(10'h020, MISS, "after_abort");

        fetch(10'h030, MISS, "coll_old", -1, '0, 4, 10'h032, ~model[10'h032]);
        fetch(10'h030, MISS, "coll_new");

        sel = 1'b1;
        for (int i = 0; i < 8; i++) prog_byte(10'(i), 8'(8'h10 + i));
        fetch(10'h006, MISS, "wrap6");
        check32("wrap6_const", rd, 32'h1716_1514);
        fetch(10'h003, JOIN, "wrap3");
        check32("wrap3_const", rd, 32'h1312_1110);
        sel = 1'b0;
        for (int i = 0; i < 8; i++) prog_byte(10'(i), 8'($urandom));

        fetch(10'h000, MISS, "seq0");
        repeat (8) @(negedge clk);
        fetch(10'h004, SEQ, "seq4");
        repeat (8) @(negedge clk);
        fetch(10'h008, SEQ, "seq8");
        repeat (8) @(negedge clk);
        fetch(10'h040, MISS, "jump40");
        fetch(10'h000, MISS, "seq0b");
        prog_byte(10'h005, ~model[10'h005]);
        repeat (8) @(negedge clk);
        fetch(10'h004, MISS, "inval4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch_unit.md
Name: instr_mem_fetch_unit

Overview:
Parametrised, multi-cycle instruction memory with a READ/BUSYWAIT handshake. It replaces the zero-state, fixed-delay instruction fetch model used with the single-cycle CPU.
- Stores a byte array of DEPTH bytes; returns little-endian words (byte at ADDRESS in bits [7:0]).
- Read latency is configurable; the CPU stalls while BUSYWAIT is high.
- A byte-wide program port lets benches and loaders fill memory at run time.

Parameters:
ADDR_W, 10, byte address width; DEPTH = 2**ADDR_W bytes
WORD_BYTES, 4, bytes per fetched word; INSTR_W = 8*WORD_BYTES
LATENCY, 4, cycles BUSYWAIT stays high on a miss; legal range 1..15

Ports:
CLK  in  1  clock; all state changes on posedge
RESET  in  1  asynchronous, active-low reset
READ  in  1  fetch request; held high until BUSYWAIT is seen low
ADDRESS  in  ADDR_W  byte address; low log2(WORD_BYTES) bits ignored (forced to 0)
READDATA  out  INSTR_W  fetched word; registered
BUSYWAIT  out  1  combinational stall: READ && state!=DONE (&& not prefetch-hit, see below)
PROG_WE  in  1  byte write enable
PROG_ADDR  in  ADDR_W  byte write address
PROG_DATA  in  8  byte write data

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, cnt=0, READDATA=0, latched address=0, prefetch buffer invalid. Memory contents are not cleared. BUSYWAIT follows its equation, so it is 1 if READ=1.
- States: IDLE, WAIT, DONE.
- IDLE: at posedge with READ=1, latch aligned ADDRESS, load cnt=LATENCY-1, go to WAIT.
- WAIT: at each posedge, if cnt!=0, decrement cnt.
  - At the posedge where cnt==0: READDATA <= {mem[a+WB-1],...,mem[a]}, go to DONE.
  - Byte indices wrap modulo DEPTH.
- DONE: BUSYWAIT=0 for exactly one cycle; READDATA holds the valid word. Next posedge goes to IDLE unconditionally.
- Timing: READ rising before edge E0 gives BUSYWAIT high from the assertion through edge E(LATENCY); low in the cycle after. A back-to-back request is sampled in IDLE one edge later.
- ADDRESS changes during WAIT are ignored; the latched address is used.
- READ dropped during WAIT aborts the fetch: next edge goes to IDLE, READDATA unchanged.
- READDATA changes only on a DONE load (or a prefetch-hit load); otherwise it holds its value.
- PROG_WE: mem[PROG_ADDR] <= PROG_DATA at posedge in any state.
  - If the write lands on the same edge as the READDATA load, the load sees the old byte.
  - The new byte is visible from the following edge.
- Simultaneous RESET=0 and PROG_WE: reset wins for control state. The memory write still occurs.

Optional Feature:
Macro INSTR_MEM_PREFETCH_EN.
- Enabled:
  - On entering DONE for word address a, a background fetch of a+WORD_BYTES starts (wrapping), taking LATENCY cycles, into a one-word buffer.
  - In IDLE, READ with an aligned address equal to a valid buffer address is a hit: BUSYWAIT=0 combinationally, READDATA <= buffer at the next edge, state goes to DONE. The next sequential prefetch then starts.
  - A request for an address that is still being prefetched waits for the remaining count instead of restarting.
  - A request for any other address cancels the prefetch and does a normal miss.
  - A PROG_WE to any byte of the buffered or in-flight word invalidates the buffer.
- Disabled: no buffer; every request takes the full LATENCY.

Test Plan:
- Reset: RESET=0 for 1 cycle mid-WAIT -> state IDLE, READDATA=0, no DONE cycle. Memory bytes previously programmed remain readable.
- Miss latency (LATENCY=4): program bytes 0..3 = 00,00,00,02. Assert READ, ADDRESS=0 -> BUSYWAIT high for 4 cycles, then low 1 cycle with READDATA=32'h02000000.
- Alignment/wrap: ADDRESS=10'h3FF -> fetches bytes 3FC..3FF. With WORD_BYTES=4, the wrap path is exercised with ADDR_W=3 and address 6 -> bytes 4..7.
- Abort and address-change: change ADDRESS 0->8 during WAIT -> word at 0 returned. Drop READ mid-WAIT -> IDLE, READDATA unchanged.
- Program collision: PROG_WE to byte 2 on the same edge as the load -> old value returned. An immediate re-read returns the new value.
- INSTR_MEM_PREFETCH_EN: sequential reads 0,4,8 spaced more than LATENCY apart -> second and third reads have BUSYWAIT=0. A jump to 0x40 -> full 4-cycle stall. A PROG_WE to byte 5 before read 4 -> miss.
